interrupt_controller: RTL and testbench
=======================================

Name: interrupt_controller

Overview:
- Upstream interrupt front end for the 5-stage pipelined CPU.
- Synchronises raw external interrupt lines and latches rising edges as pending.
- Arbitrates by fixed priority against the CP0 mask, the global disable and the in-service level.
- Presents one request plus an entrance vector to the ID stage, which redirects `pc_next`, saves EPC and returns `irq_ack`.
- Supports nesting: a strictly higher-priority source preempts a running handler; `eret` retires the innermost level.

Parameters:
- N, 3, number of interrupt sources; the highest index has the highest priority.
- VEC_BASE, 32'h0000_0400, entrance address of source 0.
- VEC_STRIDE, 32'h0000_0200, address distance between consecutive source entrances.

Ports:
- clk  in  1  CPU clock; the same gated clock as the pipeline.
- rst_n  in  1  reset, asynchronous assert, active-low.
- irq_src  in  N  raw interrupt lines, asynchronous, level; a rising edge requests.
- irq_mask  in  N  CP0 mask register; 1 = source enabled.
- irq_disable  in  1  CP0 global disable; 1 = no new requests.
- irq_ack  in  1  one-cycle pulse from ID when the CPU takes the request.
- eret  in  1  one-cycle pulse from ID on exception return.
- irq_req  out  1  registered request to the pipeline.
- irq_id  out  $clog2(N)  index of the requested source.
- irq_vector  out  32  entrance address, VEC_BASE + irq_id*VEC_STRIDE.
- irq_pending  out  N  pending bits, for CP0 read-back.
- irq_in_service  out  N  in-service bits, for CP0 read-back.

Behaviour:
- Reset values: all outputs 0; sync and edge flops 0; FSM in IDLE. Reset mid-request drops irq_req immediately and discards all pending and in-service state.
- Synchronisation: 2-flop synchroniser per line, plus a previous-value flop.
  - rise[i] = sync2[i] & ~prev[i].
  - A line first sampled high at edge T0 sets pending[i] at T0+2.
  - irq_req rises at T0+3 if the source is eligible.
  - Level held high produces exactly one event. A pulse shorter than one clock period is not guaranteed to register.
- Eligibility: eligible[i] = pending[i] & irq_mask[i] & ~irq_disable & (i > index of highest set in_service bit, or no in_service bit set). The winner is the highest eligible index.
- FSM IDLE:
  - If any source is eligible, the next edge registers irq_id = winner, irq_vector = computed address, irq_req = 1, and the FSM moves to REQ.
- FSM REQ:
  - irq_id and irq_vector are frozen, even if a higher-priority source becomes pending.
  - irq_ack=1: at that edge pending[id] is cleared, in_service[id] is set, irq_req falls, and the FSM returns to IDLE. The next arbitration occurs one cycle later, so back-to-back requests are at least 2 cycles apart.
  - irq_ack=0 and source[id] no longer eligible (mask cleared or disable set): irq_req falls next edge, the FSM returns to IDLE, and the pending bit is retained.
  - irq_ack together with loss of eligibility in the same cycle: ack wins.
- eret:
  - Clears the highest set in_service bit at the edge.
  - eret with no bit set is ignored.
  - eret in REQ does not disturb the frozen request.
- Simultaneous events:
  - A new rise[i] in the same cycle as the ack of i leaves pending[i] = 1 (set wins).
  - eret and irq_ack in the same cycle: the eret clear is applied first, then the ack set (a different or the same bit).
- Other boundaries:
  - irq_ack while in IDLE is ignored.
  - irq_vector arithmetic is 32-bit and wraps modulo 2^32; overflow is not checked.
  - irq_pending and irq_in_service are direct register outputs, with no combinational path from inputs.

Decomposition:
- Shared package/header intc_pkg:
  - FSM state encoding: IDLE=1'b0, REQ=1'b1.
  - Default VEC_BASE and VEC_STRIDE constants.
  - Function prio_idx(vector) returning the highest set index, or a no-bit flag.
- Sub-module irq_sync_edge:
  - Parameterised width.
  - 2-flop synchroniser, prev flop and rise output.
  - Async active-low reset.
- The top level holds the pending/in-service registers, the arbiter and the FSM.

Test Plan:
1. Reset then irq_src[1] rises, mask=3'b111, disable=0 -> irq_req=1 at T0+3 with irq_id=1, irq_vector=32'h600; ack -> pending=000, in_service=010, irq_req=0 next edge.
2. Sources 0 and 2 rise together -> first request id=2 (vector 32'h800); after ack, id=0 is not requested (lower than in-service 2) until eret, then id=0 with vector 32'h400 two cycles later.
3. Nesting: in_service=001, source 2 rises -> request id=2; ack -> in_service=101; eret -> 001; eret -> 000.
4. Masking: source 1 pending with mask=3'b101 -> no irq_req; set mask bit -> irq_req next edge; set disable during REQ without ack -> irq_req drops and pending[1] stays 1.
5. Corners: rise on source 2 in the same cycle as its ack -> pending[2] remains 1; irq_ack in IDLE and eret with in_service=000 -> no state change; rst_n low during REQ -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/intc_pkg.sv
// Shared types and helpers for the interrupt controller: FSM encoding,
// default vector constants and a highest-set-bit priority encoder.
package intc_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_t;

   localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0400;
   localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0200;

   // Widest source vector the encoder accepts; narrower vectors are zero-extended.
   localparam int PRIO_W = 32;

   typedef struct packed {
      logic       found;
      logic [4:0] idx;
   } prio_t;

   // Index of the highest set bit; found=0 when the vector is empty.
   function automatic prio_t prio_idx(input logic [PRIO_W-1:0] v);
      prio_t r;
      r.found = 1'b0;
      r.idx   = '0;
      for (int i = 0; i < PRIO_W; i++) begin
         if (v[i]) begin
            r.found = 1'b1;
            r.idx   = 5'(i);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser per raw interrupt line plus a previous-value flop;
// o_rise pulses for one cycle on each synchronised rising edge.
module irq_sync_edge #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] i_async,
   output logic [W-1:0] o_rise
);

   logic [W-1:0] r_sync1;
   logic [W-1:0] r_sync2;
   logic [W-1:0] r_prev;

   // Metastability filter followed by one cycle of history for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_prev  <= '0;
      end else begin
         r_sync1 <= i_async;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign o_rise = r_sync2 & ~r_prev;

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt front end: latches synchronised rising edges as pending,
// arbitrates by fixed priority against mask, global disable and the
// in-service level, and hands one request with its vector to ID.
module interrupt_controller
   import intc_pkg::*;
#(
   parameter int          N          = 3,
   parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
   parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DEF,
   localparam int         IDW        = (N > 1) ? $clog2(N) : 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   irq_src,
   input  logic [N-1:0]   irq_mask,
   input  logic           irq_disable,
   input  logic           irq_ack,
   input  logic           eret,
   output logic           irq_req,
   output logic [IDW-1:0] irq_id,
   output logic [31:0]    irq_vector,
   output logic [N-1:0]   irq_pending,
   output logic [N-1:0]   irq_in_service
);

   state_t         r_state;
   state_t         w_state_nxt;
   logic           r_req;
   logic           w_req_nxt;
   logic [IDW-1:0] r_id;
   logic [IDW-1:0] w_id_nxt;
   logic [31:0]    r_vec;
   logic [31:0]    w_vec_nxt;
   logic [N-1:0]   r_pend;
   logic [N-1:0]   r_isv;
   logic [N-1:0]   w_rise;
   logic [N-1:0]   w_elig;
   logic [N-1:0]   w_ack_set;
   logic [N-1:0]   w_eret_clr;
   prio_t          w_isv_top;
   prio_t          w_win;

   irq_sync_edge #(.W(N)) u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_async (irq_src),
      .o_rise  (w_rise)
   );

   // Eligibility: enabled, not globally disabled, and strictly above the active level.
   always_comb begin
      w_elig    = '0;
      w_isv_top = prio_idx(32'(r_isv));
      for (int i = 0; i < N; i++) begin
         w_elig[i] = r_pend[i] & irq_mask[i] & ~irq_disable &
                     (~w_isv_top.found | (i > int'(w_isv_top.idx)));
      end
      w_win = prio_idx(32'(w_elig));
   end

   // Ack only counts while a request is outstanding; eret retires the innermost level.
   always_comb begin
      w_ack_set  = '0;
      w_eret_clr = '0;
      if ((r_state == REQ) && irq_ack) begin
         w_ack_set = N'(1) << r_id;
      end
      if (eret && w_isv_top.found) begin
         w_eret_clr = N'(1) << w_isv_top.idx;
      end
   end

   // Request FSM: launch the winner from IDLE, hold it frozen in REQ until ack or lost eligibility.
   always_comb begin
      w_state_nxt = r_state;
      w_req_nxt   = r_req;
      w_id_nxt    = r_id;
      w_vec_nxt   = r_vec;
      case (r_state)
         IDLE: begin
            if (w_win.found) begin
               w_state_nxt = REQ;
               w_req_nxt   = 1'b1;
               w_id_nxt    = w_win.idx[IDW-1:0];
               w_vec_nxt   = VEC_BASE + 32'(w_win.idx) * VEC_STRIDE;
            end
         end
         REQ: begin
            if (irq_ack || !w_elig[r_id]) begin
               w_state_nxt = IDLE;
               w_req_nxt   = 1'b0;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_req_nxt   = 1'b0;
         end
      endcase
   end

   // FSM state and registered request outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_req   <= 1'b0;
         r_id    <= '0;
         r_vec   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_req   <= w_req_nxt;
         r_id    <= w_id_nxt;
         r_vec   <= w_vec_nxt;
      end
   end

   // Pending: ack clears, new edge sets (set wins). In-service: eret clear before ack set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend <= '0;
         r_isv  <= '0;
      end else begin
         r_pend <= (r_pend & ~w_ack_set) | w_rise;
         r_isv  <= (r_isv & ~w_eret_clr) | w_ack_set;
      end
   end

   assign irq_req        = r_req;
   assign irq_id         = r_id;
   assign irq_vector     = r_vec;
   assign irq_pending    = r_pend;
   assign irq_in_service = r_isv;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed scenarios against
// constants, then randomized traffic against a behavioural model.
module tb_interrupt_controller;

   localparam int N = 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] irq_src = '0;
   logic [N-1:0] irq_mask = '1;
   logic         irq_disable = 1'b0;
   logic         irq_ack = 1'b0;
   logic         eret = 1'b0;
   logic         irq_req;
   logic [1:0]   irq_id;
   logic [31:0]  irq_vector;
   logic [N-1:0] irq_pending;
   logic [N-1:0] irq_in_service;

   int n_vec = 0;
   int n_err = 0;

   interrupt_controller dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .irq_src        (irq_src),
      .irq_mask       (irq_mask),
      .irq_disable    (irq_disable),
      .irq_ack        (irq_ack),
      .eret           (eret),
      .irq_req        (irq_req),
      .irq_id         (irq_id),
      .irq_vector     (irq_vector),
      .irq_pending    (irq_pending),
      .irq_in_service (irq_in_service)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural reference model ----------------
   function automatic int top_of(input logic [N-1:0] v);
      int t = -1;
      for (int i = 0; i < N; i++) if (v[i]) t = i;
      return t;
   endfunction

   function automatic bit eligible(input int i, input logic [N-1:0] pend,
                                   input logic [N-1:0] isv, input logic [N-1:0] mask,
                                   input logic dis);
      return pend[i] && mask[i] && !dis && (i > top_of(isv));
   endfunction

   function automatic logic [31:0] vec_of(input int id);
      return 32'h0000_0400 + 32'(id) * 32'h0000_0200;
   endfunction

   logic [N-1:0] m_s0, m_s1, m_s2;   // samples of irq_src taken 1, 2, 3 edges ago
   logic [N-1:0] m_pend, m_isv;
   bit           m_req;
   int           m_id;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_s0 <= '0; m_s1 <= '0; m_s2 <= '0;
         m_pend <= '0; m_isv <= '0; m_req <= 1'b0; m_id <= 0;
      end else begin : step
         logic [N-1:0] pend, isv;
         int t, w;
         pend = m_pend;
         isv  = m_isv;
         t = top_of(m_isv);
         if (eret && t >= 0) isv[t] = 1'b0;
         if (m_req) begin
            if (irq_ack) begin
               pend[m_id] = 1'b0;
               isv[m_id]  = 1'b1;
               m_req <= 1'b0;
            end else if (!eligible(m_id, m_pend, m_isv, irq_mask, irq_disable)) begin
               m_req <= 1'b0;
            end
         end else begin
            w = -1;
            for (int i = N - 1; i >= 0; i--)
               if (w < 0 && eligible(i, m_pend, m_isv, irq_mask, irq_disable)) w = i;
            if (w >= 0) begin
               m_req <= 1'b1;
               m_id  <= w;
            end
         end
         pend = pend | (m_s1 & ~m_s2);
         m_pend <= pend;
         m_isv  <= isv;
         m_s0 <= irq_src;
         m_s1 <= m_s0;
         m_s2 <= m_s1;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic flush_src();
      irq_src = '0;
      cyc(4);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      cyc(3);
      n_vec++;
      if (irq_req !== 1'b0 || irq_id !== 2'd0 || irq_vector !== 32'h0 ||
          irq_pending !== 3'b000 || irq_in_service !== 3'b000) begin
         n_err++;
         $display("FAIL reset: req=%b id=%0d vec=%h pend=%b isv=%b, want all zero",
                  irq_req, irq_id, irq_vector, irq_pending, irq_in_service);
      end
      rst_n = 1'b1;
      cyc(1);
   endtask

   task automatic test_basic();
      irq_src = 3'b010;
      cyc(3);
      n_vec++;
      if (irq_pending !== 3'b010 || irq_req !== 1'b0) begin
         n_err++;
         $display("FAIL basic_pend: pend=%b req=%b, want pend=010 req=0", irq_pending, irq_req);
      end
      cyc(1);
      n_vec++;
      if (irq_req !== 1'b1 || irq_id !== 2'd1 || irq_vector !== 32'h600) begin
         n_err++;
         $display("FAIL basic_req: req=%b id=%0d vec=%h, want 1/1/00000600", irq_req, irq_id, irq_vector);
      end
      irq_ack = 1'b1;
      cyc(1);
      irq_ack = 1'b0;
      n_vec++;
      if (irq_pending !== 3'b000 || irq_in_service !== 3'b010 || irq_req !== 1'b0) begin
         n_err++;
         $display("FAIL basic_ack: pend=%b isv=%b req=%b, want 000/010/0", irq_pending, irq_in_service, irq_req);
      end
      cyc(3);
      n_vec++;
      if (irq_pending !== 3'b000 || irq_req !== 1'b0) begin
         n_err++;
         $display("FAIL basic_level_once: pend=%b req=%b, want 000/0", irq_pending, irq_req);
      end
      eret = 1'b1;
      cyc(1);
      eret = 1'b0;
      n_vec++;
      if (irq_in_service !== 3'b000) begin
         n_err++;
         $display("FAIL basic_eret: isv=%b, want 000", irq_in_service);
      end
      flush_src();
   endtask

   task automatic test_priority();
      irq_src = 3'b101;
      cyc(4);
      n_vec++;
      if (irq_req !== 1'b1 || irq_id !== 2'd2 || irq_vector !== 32'h800) begin
         n_err++;
         $display("FAIL prio_first: req=%b id=%0d vec=%h, want 1/2/00000800", irq_req, irq_id, irq_vector);
      end
      irq_ack = 1'b1;
      cyc(1);
      irq_ack = 1'b0;
      cyc(3);
      n_vec++;
      if (irq_req !== 1'b0 || irq_pending !== 3'b001 || irq_in_service !== 3'b100) begin
         n_err++;
         $display("FAIL prio_blocked: req=%b pend=%b isv=%b, want 0/001/100", irq_req, irq_pending, irq_in_service);
      end
      eret = 1'b1;
      cyc(1);
      eret = 1'b0;
      n_vec++;
      if (irq_req !== 1'b0 || irq_in_service !== 3'b000) begin
         n_err++;
         $display("FAIL prio_eret: req=%b isv=%b, want 0/000", irq_req, irq_in_service);
      end
      cyc(1);
      n_vec++;
      if (irq_req !== 1'b1 || irq_id !== 2'd0 || irq_vector !== 32'h400) begin
         n_err++;
         $display("FAIL prio_second: req=%b id=%0d vec=%h, want 1/0/00000400", irq_req, irq_id, irq_vector);
      end
      irq_ack = 1'b1;
      cyc(1);
      irq_ack = 1'b0;
      eret = 1'b1;
      cyc(1);
      eret = 1'b0;
      flush_src();
   endtask

   task automatic test_nesting();
      irq_src = 3'b001;
      cyc(4);
      irq_ack = 1'b1;
      cyc(1);
      irq_ack = 1'b0;
      n_vec++;
      if (irq_in_service !== 3'b001) begin
         n_err++;
         $display("FAIL nest_outer: isv=%b, want 001", irq_in_service);
      end
      irq_src = 3'b101;
      cyc(4);
      n_vec++;
      if (irq_req !== 1'b1 || irq_id !== 2'd2 || irq_vector !== 32'h800) begin
         n_err++;
         $display("FAIL nest_preempt: req=%b id=%0d vec=%h, want 1/2/00000800", irq_req, irq_id, irq_vector);
      end
      irq_ack = 1'b1;
      cyc(1);
      irq_ack = 1'b0;
      n_vec++;
      if (irq_in_service !== 3'b101) begin
         n_err++;
         $display("FAIL nest_inner: isv=%b, want 101", irq_in_service);
      end
      eret = 1'b1;
      cyc(1);
      n_vec++;
      if (irq_in_service !== 3'b001) begin
         n_err++;
         $display("FAIL nest_eret1: isv=%b, want 001", irq_in_service);
      end
      cyc(1);
      eret = 1'b0;
      n_vec++;
      if (irq_in_service !== 3'b000) begin
         n_err++;
         $display("FAIL nest_eret2: isv=%b, want 000", irq_in_service);
      end
      flush_src();
   endtask

   task automatic test_masking();
      irq_mask = 3'b101;
      irq_src  = 3'b010;
      cyc(5);
      n_vec++;
      if (irq_req !== 1'b0 || irq_pending !== 3'b010) begin
         n_err++;
         $display("FAIL mask_block: req=%b pend=%b, want 0/010", irq_req, irq_pending);
      end
      irq_mask = 3'b111;
      cyc(1);
      n_vec++;
      if (irq_req !== 1'b1 || irq_id !== 2'd1) begin
         n_err++;
         $display("FAIL mask_enable: req=%b id=%0d, want 1/1", irq_req, irq_id);
      end
      irq_disable = 1'b1;
      cyc(1);
      n_vec++;
      if (irq_req !== 1'b0 || irq_pending !== 3'b010) begin
         n_err++;
         $display("FAIL mask_disable: req=%b pend=%b, want 0/010", irq_req, irq_pending);
      end
      irq_disable = 1'b0;
      cyc(1);
      n_vec++;
      if (irq_req !== 1'b1 || irq_id !== 2'd1) begin
         n_err++;
         $display("FAIL mask_reenable: req=%b id=%0d, want 1/1", irq_req, irq_id);
      end
      irq_ack = 1'b1;
      cyc(1);
      irq_ack = 1'b0;
      eret = 1'b1;
      cyc(1);
      eret = 1'b0;
      flush_src();
   endtask

   task automatic test_corners();
      // rise on source 2 lands on the same edge as its ack
      irq_src = 3'b100;
      cyc(4);
      n_vec++;
      if (irq_req !== 1'b1 || irq_id !== 2'd2) begin
         n_err++;
         $display("FAIL corner_req2: req=%b id=%0d, want 1/2", irq_req, irq_id);
      end
      irq_src = 3'b000;
      cyc(1);
      irq_src = 3'b100;
      cyc(2);
      n_vec++;
      if (irq_req !== 1'b1 || irq_id !== 2'd2) begin
         n_err++;
         $display("FAIL corner_hold: req=%b id=%0d, want 1/2", irq_req, irq_id);
      end
      irq_ack = 1'b1;
      cyc(1);
      irq_ack = 1'b0;
      n_vec++;
      if (irq_pending !== 3'b100 || irq_in_service !== 3'b100 || irq_req !== 1'b0) begin
         n_err++;
         $display("FAIL corner_setwins: pend=%b isv=%b req=%b, want 100/100/0", irq_pending, irq_in_service, irq_req);
      end
      eret = 1'b1;
      cyc(1);
      eret = 1'b0;
      cyc(1);
      n_vec++;
      if (irq_req !== 1'b1 || irq_id !== 2'd2 || irq_vector !== 32'h800) begin
         n_err++;
         $display("FAIL corner_rereq: req=%b id=%0d vec=%h, want 1/2/00000800", irq_req, irq_id, irq_vector);
      end
      irq_ack = 1'b1;
      cyc(1);
      irq_ack = 1'b0;
      eret = 1'b1;
      cyc(1);
      eret = 1'b0;
      flush_src();

      // ack in IDLE and eret with nothing in service are ignored
      irq_mask = 3'b000;
      irq_src  = 3'b010;
      cyc(4);
      irq_ack = 1'b1;
      eret    = 1'b1;
      cyc(1);
      irq_ack = 1'b0;
      eret    = 1'b0;
      n_vec++;
      if (irq_pending !== 3'b010 || irq_in_service !== 3'b000 || irq_req !== 1'b0) begin
         n_err++;
         $display("FAIL corner_idle_ack: pend=%b isv=%b req=%b, want 010/000/0", irq_pending, irq_in_service, irq_req);
      end

      // asynchronous reset while a request is outstanding
      irq_mask = 3'b111;
      cyc(1);
      n_vec++;
      if (irq_req !== 1'b1 || irq_id !== 2'd1) begin
         n_err++;
         $display("FAIL corner_prereset: req=%b id=%0d, want 1/1", irq_req, irq_id);
      end
      #1 rst_n = 1'b0;
      #1;
      n_vec++;
      if (irq_req !== 1'b0 || irq_id !== 2'd0 || irq_vector !== 32'h0 ||
          irq_pending !== 3'b000 || irq_in_service !== 3'b000) begin
         n_err++;
         $display("FAIL corner_async_reset: req=%b id=%0d vec=%h pend=%b isv=%b, want all zero",
                  irq_req, irq_id, irq_vector, irq_pending, irq_in_service);
      end
      irq_src = '0;
      cyc(2);
      rst_n = 1'b1;
      cyc(1);
   endtask

   task automatic test_random();
      rst_n = 1'b0;
      irq_src = '0; irq_mask = '1; irq_disable = 1'b0; irq_ack = 1'b0; eret = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         n_vec++;
         if (irq_req !== m_req || irq_pending !== m_pend || irq_in_service !== m_isv ||
             (m_req && (int'(irq_id) !== m_id || irq_vector !== vec_of(m_id)))) begin
            n_err++;
            $display("FAIL random cyc %0d: req=%b id=%0d vec=%h pend=%b isv=%b, want req=%b id=%0d vec=%h pend=%b isv=%b",
                     c, irq_req, irq_id, irq_vector, irq_pending, irq_in_service,
                     m_req, m_id, vec_of(m_id), m_pend, m_isv);
         end
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 5) == 0) irq_src[i] = ~irq_src[i];
         if ($urandom_range(0, 15) == 0)
            irq_mask = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
         if ($urandom_range(0, 15) == 0) irq_disable = ~irq_disable;
         irq_ack = (m_req && $urandom_range(0, 2) == 0) || ($urandom_range(0, 31) == 0);
         eret    = ($urandom_range(0, 11) == 0);
      end
      irq_ack = 1'b0;
      eret    = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_priority();
      test_nesting();
      test_masking();
      test_corners();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
